// File: rtl/mnacidpro_valve_seq.sv
// Purpose: valve/pump sequencer turning single fluid commands into c1..c13 / p1..p3 drive.
// Latency: valves open the cycle after accept; done follows dur + SETTLE cycles later.
// Backpressure: cmd_ready is high only in IDLE without rst/abort; one command in flight.
module mnacidpro_valve_seq #(
   parameter int SETTLE = 8,
   parameter int PH_CYC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [2:0]  cmd_sel,
   input  logic [7:0]  cmd_dur,
   input  logic        abort,
   output logic [12:0] c,
   output logic [2:0]  p,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int CW = $clog2(255 * 6 * PH_CYC + 1);
   localparam int HW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
   localparam int PW = (PH_CYC > 1) ? $clog2(PH_CYC) : 1;

   localparam logic [12:0] C_CLOSED = 13'h1FFF;
   localparam logic [2:0]  P_IDLE   = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLD} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [HW-1:0]   hcnt, hcnt_nx;
   logic [PW-1:0]   pcnt, pcnt_nx;
   logic [2:0]      ph, ph_nx;
   logic            is_mix, is_mix_nx;
   logic            aborted, aborted_nx;
   logic [12:0]     c_nx;
   logic [2:0]      p_nx;
   logic            done_nx, err_nx;
   logic [12:0]     open_mask;
   logic            illegal;
   logic            accept;

   // Peristaltic 6-phase waveform.
   function automatic logic [2:0] mix_p(input logic [2:0] idx);
      case (idx)
         3'd0:    mix_p = 3'b110;
         3'd1:    mix_p = 3'b100;
         3'd2:    mix_p = 3'b101;
         3'd3:    mix_p = 3'b001;
         3'd4:    mix_p = 3'b011;
         default: mix_p = 3'b010;
      endcase
   endfunction

   assign cmd_ready = (state == S_IDLE) & ~rst & ~abort;
   assign accept    = cmd_valid & cmd_ready;
   assign busy      = (state != S_IDLE);

   // Decode the command into the set of valves to open and flag illegal selects.
   always_comb begin
      open_mask = 13'h0000;
      illegal   = 1'b0;
      case (cmd_op)
         2'd0: begin
            case (cmd_sel)
               3'd0:    open_mask = 13'h0009;
               3'd1:    open_mask = 13'h000A;
               3'd2:    open_mask = 13'h000C;
               3'd3:    open_mask = 13'h0010;
               3'd4:    open_mask = 13'h0020;
               default: illegal   = 1'b1;
            endcase
         end
         2'd1: open_mask = 13'h0040;
         2'd2: open_mask = 13'h0000;
         default: begin
            open_mask = 13'h0400 | (cmd_sel[2] ? 13'h1000 : 13'h0800);
            case (cmd_sel[1:0])
               2'd0:    open_mask = open_mask | 13'h0080;
               2'd1:    open_mask = open_mask | 13'h0100;
               2'd2:    open_mask = open_mask | 13'h0200;
               default: illegal   = 1'b1;
            endcase
         end
      endcase
   end

   // Next-state and next-output logic; every exit from ACTIVE passes through a closed HOLD.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      hcnt_nx    = hcnt;
      pcnt_nx    = pcnt;
      ph_nx      = ph;
      is_mix_nx  = is_mix;
      aborted_nx = aborted;
      c_nx       = c;
      p_nx       = p;
      done_nx    = 1'b0;
      err_nx     = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               aborted_nx = 1'b0;
               if (illegal) begin
                  err_nx = 1'b1;
               end else if (cmd_dur == 8'd0) begin
                  state_nx = S_HOLD;
                  hcnt_nx  = HW'(SETTLE - 1);
                  c_nx     = C_CLOSED;
                  p_nx     = P_IDLE;
               end else begin
                  state_nx  = S_ACTIVE;
                  is_mix_nx = (cmd_op == 2'd2);
                  ph_nx     = 3'd0;
                  pcnt_nx   = '0;
                  c_nx      = C_CLOSED & ~open_mask;
                  if (cmd_op == 2'd2) begin
                     cnt_nx = CW'(cmd_dur) * CW'(6 * PH_CYC) - CW'(1);
                     p_nx   = mix_p(3'd0);
                  end else begin
                     cnt_nx = CW'(cmd_dur) - CW'(1);
                     p_nx   = P_IDLE;
                  end
               end
            end
         end
         S_ACTIVE: begin
            if (abort || cnt == '0) begin
               state_nx   = S_HOLD;
               hcnt_nx    = HW'(SETTLE - 1);
               c_nx       = C_CLOSED;
               p_nx       = P_IDLE;
               aborted_nx = abort;
            end else begin
               cnt_nx = cnt - CW'(1);
               if (is_mix) begin
                  if (pcnt == PW'(PH_CYC - 1)) begin
                     pcnt_nx = '0;
                     ph_nx   = (ph == 3'd5) ? 3'd0 : ph + 3'd1;
                     p_nx    = mix_p(ph_nx);
                  end else begin
                     pcnt_nx = pcnt + PW'(1);
                  end
               end
            end
         end
         S_HOLD: begin
            if (hcnt == '0) begin
               state_nx   = S_IDLE;
               done_nx    = ~aborted;
               aborted_nx = 1'b0;
            end else begin
               hcnt_nx = hcnt - HW'(1);
            end
         end
         default: begin
            state_nx = S_IDLE;
            c_nx     = C_CLOSED;
            p_nx     = P_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset closes everything and clears all counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         hcnt    <= '0;
         pcnt    <= '0;
         ph      <= 3'd0;
         is_mix  <= 1'b0;
         aborted <= 1'b0;
         c       <= C_CLOSED;
         p       <= P_IDLE;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         hcnt    <= hcnt_nx;
         pcnt    <= pcnt_nx;
         ph      <= ph_nx;
         is_mix  <= is_mix_nx;
         aborted <= aborted_nx;
         c       <= c_nx;
         p       <= p_nx;
         done    <= done_nx;
         err     <= err_nx;
      end
   end

endmodule

// File: tb/tb_mnacidpro_valve_seq.sv
// Purpose: directed self-checking bench for mnacidpro_valve_seq.
// Latency: inputs driven 1ns after posedge, outputs sampled at negedge.
// Backpressure: commands are only offered when the sequencer is idle.
module tb_mnacidpro_valve_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [2:0]  cmd_sel;
   logic [7:0]  cmd_dur;
   logic        abort;
   logic [12:0] c;
   logic [2:0]  p;
   logic        busy;
   logic        done;
   logic        err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [2:0] ptab [6];

   mnacidpro_valve_seq #(.SETTLE(8), .PH_CYC(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_dur(cmd_dur), .abort(abort),
      .c(c), .p(p), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a command in the current cycle (cycle 0); returns at the start of cycle 1.
   task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [7:0] dur);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_sel   = sel;
      cmd_dur   = dur;
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      logic [12:0] ec;
      logic [2:0]  ep;
      ptab[0] = 3'b110; ptab[1] = 3'b100; ptab[2] = 3'b101;
      ptab[3] = 3'b001; ptab[4] = 3'b011; ptab[5] = 3'b010;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_sel = 3'd0; cmd_dur = 8'd0; abort = 1'b0;

      // Reset state
      step(); step();
      @(negedge clk);
      chk("rst_c", 32'(c), 32'h1FFF);
      chk("rst_p", 32'(p), 32'h7);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_ready", 32'(cmd_ready), 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(cmd_ready), 1);
      step();

      // 1: FILL sel=1 dur=5
      issue(2'd0, 3'd1, 8'd5);
      for (int cy = 1; cy <= 15; cy++) begin
         @(negedge clk);
         ec = (cy <= 5) ? 13'h1FF5 : 13'h1FFF;
         chk("t1_c", 32'(c), 32'(ec));
         chk("t1_p", 32'(p), 32'h7);
         chk("t1_busy", 32'(busy), 32'(cy <= 13));
         chk("t1_done", 32'(done), 32'(cy == 14));
         chk("t1_ready", 32'(cmd_ready), 32'(cy >= 14));
         step();
      end

      // 2: MIX dur=2
      issue(2'd2, 3'd0, 8'd2);
      for (int cy = 1; cy <= 58; cy++) begin
         @(negedge clk);
         ep = (cy <= 48) ? ptab[((cy - 1) / 4) % 6] : 3'b111;
         chk("t2_p", 32'(p), 32'(ep));
         chk("t2_c", 32'(c), 32'h1FFF);
         chk("t2_busy", 32'(busy), 32'(cy <= 56));
         chk("t2_done", 32'(done), 32'(cy == 57));
         step();
      end

      // 3: DISPENSE sel=101 dur=3
      issue(2'd3, 3'b101, 8'd3);
      for (int cy = 1; cy <= 13; cy++) begin
         @(negedge clk);
         ec = (cy <= 3) ? 13'h0AFF : 13'h1FFF;
         chk("t3_c", 32'(c), 32'(ec));
         chk("t3_done", 32'(done), 32'(cy == 12));
         step();
      end

      // 4a: illegal FILL sel=6, then illegal DISPENSE sel[1:0]=3
      issue(2'd0, 3'd6, 8'd4);
      for (int cy = 1; cy <= 3; cy++) begin
         @(negedge clk);
         chk("t4a_err", 32'(err), 32'(cy == 1));
         chk("t4a_c", 32'(c), 32'h1FFF);
         chk("t4a_ready", 32'(cmd_ready), 1);
         chk("t4a_busy", 32'(busy), 0);
         chk("t4a_done", 32'(done), 0);
         step();
      end
      issue(2'd3, 3'd3, 8'd4);
      @(negedge clk);
      chk("t4a_err_disp", 32'(err), 1);
      chk("t4a_c_disp", 32'(c), 32'h1FFF);
      step();

      // 4b: FILL dur=0
      issue(2'd0, 3'd0, 8'd0);
      for (int cy = 1; cy <= 10; cy++) begin
         @(negedge clk);
         chk("t4b_c", 32'(c), 32'h1FFF);
         chk("t4b_busy", 32'(busy), 32'(cy <= 8));
         chk("t4b_done", 32'(done), 32'(cy == 9));
         step();
      end

      // 5: FILL sel=0 dur=10, abort at cycle 3
      issue(2'd0, 3'd0, 8'd10);
      for (int cy = 1; cy <= 13; cy++) begin
         if (cy == 3) abort = 1'b1;
         if (cy == 4) abort = 1'b0;
         @(negedge clk);
         ec = (cy <= 3) ? 13'h1FF6 : 13'h1FFF;
         chk("t5_c", 32'(c), 32'(ec));
         chk("t5_busy", 32'(busy), 32'(cy <= 11));
         chk("t5_done", 32'(done), 0);
         chk("t5_ready", 32'(cmd_ready), 32'(cy >= 12));
         step();
      end

      // 5b: abort together with cmd_valid in IDLE blocks acceptance
      abort = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_sel = 3'd0; cmd_dur = 8'd3;
      @(negedge clk);
      chk("t5b_ready", 32'(cmd_ready), 0);
      step();
      abort = 1'b0; cmd_valid = 1'b0;
      @(negedge clk);
      chk("t5b_busy", 32'(busy), 0);
      chk("t5b_c", 32'(c), 32'h1FFF);
      step();

      // 6: reset at cycle 20 of MIX dur=5, new FILL sel=2 accepted at 21
      issue(2'd2, 3'd0, 8'd5);
      for (int cy = 1; cy <= 22; cy++) begin
         if (cy == 20) rst = 1'b1;
         if (cy == 21) begin
            rst = 1'b0;
            cmd_valid = 1'b1; cmd_op = 2'd0; cmd_sel = 3'd2; cmd_dur = 8'd2;
         end
         if (cy == 22) cmd_valid = 1'b0;
         @(negedge clk);
         if (cy <= 20) begin
            chk("t6_mix_p", 32'(p), 32'(ptab[((cy - 1) / 4) % 6]));
            chk("t6_mix_busy", 32'(busy), 1);
         end else if (cy == 21) begin
            chk("t6_rst_p", 32'(p), 32'h7);
            chk("t6_rst_c", 32'(c), 32'h1FFF);
            chk("t6_rst_busy", 32'(busy), 0);
            chk("t6_rst_ready", 32'(cmd_ready), 1);
         end else begin
            chk("t6_fill_c", 32'(c), 32'h1FF3);
            chk("t6_fill_busy", 32'(busy), 1);
         end
         step();
      end
      // FILL dur=2 accepted at 21: done at 21+2+8+1 = 32
      for (int cy = 23; cy <= 33; cy++) begin
         @(negedge clk);
         chk("t6_fill_done", 32'(done), 32'(cy == 32));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mnacidpro_valve_seq.md
# mnacidpro_valve_seq

Valve-control sequencer that sits directly upstream of the mnacidpro acid-processing fluidic netlist. It turns one-at-a-time fluid commands (fill, ring-load, mix, dispense) into the 13 valve control lines c1..c13 and the 3 peristaltic pump lines p1..p3 that the chip's valves consume. It enforces break-before-make settling, generates the 6-phase peristaltic waveform, and reports completion.

## Interface

**Control-line convention.** A control bit of 1 pressurises the valve, which closes it. A 0 opens it. Mapping: c[i-1] drives ci; p[0]=p1, p[1]=p2, p[2]=p3.

**Parameters**
- SETTLE, default 8: closed-hold cycles after every operation. Must be ≥1.
- PH_CYC, default 4: cycles per pump phase. Must be ≥1.

**Ports**
- clk  input  1  clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  combinational: state==IDLE & !rst & !abort.
- cmd_op  input  2  0=FILL, 1=RING_LOAD, 2=MIX, 3=DISPENSE.
- cmd_sel  input  3  source/destination select.
- cmd_dur  input  8  active cycles (FILL, RING_LOAD, DISPENSE) or pump rotations (MIX).
- abort  input  1  cancel current operation.
- c  output  13  valve controls, registered.
- p  output  3  pump controls, registered.
- busy  output  1  high in ACTIVE or HOLD.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle illegal-command pulse.

## Operation

**States.** IDLE, ACTIVE, HOLD.
- In IDLE and HOLD: c=13'h1FFF, p=3'b111.
- Accept rule: a command is accepted on a clk edge where cmd_valid & cmd_ready.
- cmd_dur==0: skip ACTIVE and go straight to HOLD.

**Valve sets opened in ACTIVE.** Every other valve stays closed.
- FILL
  - sel 0 → c1, c4
  - sel 1 → c2, c4
  - sel 2 → c3, c4
  - sel 3 → c5
  - sel 4 → c6
  - sel 5–7 are illegal.
- RING_LOAD: c7. sel is ignored.
- MIX: all c closed; the ring is isolated. p steps phases 0..5, PH_CYC cycles each, then wraps. p values: 110, 100, 101, 001, 011, 010. ACTIVE lasts cmd_dur×6×PH_CYC cycles.
- DISPENSE: c11, plus a source and a destination.
  - Source: sel[1:0] 0 → c8, 1 → c9, 2 → c10, 3 is illegal.
  - Destination: sel[2]=0 → c12, sel[2]=1 → c13.
- Outside MIX, p=111.

**Illegal commands.** They are accepted. err pulses the cycle after acceptance. State stays IDLE and no valve changes. done is not asserted.

**Transitions.**
- ACTIVE → HOLD when the duration count expires.
- HOLD lasts exactly SETTLE cycles, then IDLE.
- done pulses on the first IDLE cycle after HOLD.

**Abort.**
- abort in ACTIVE: c/p all closed the next cycle and enter HOLD (full SETTLE). No done is issued.
- abort in IDLE or HOLD: no effect beyond dropping cmd_ready.
- abort in the same cycle as cmd_valid: the command is not accepted, because ready is low.

**Reset.** rst at any time gives, on the next cycle: state IDLE, c=1FFF, p=111, busy=0, done=0, err=0, all counters cleared.

**Counter widths.** Size the MIX counters for 255×6×PH_CYC without overflow.

## Timing
- Accept at edge k: ACTIVE outputs are visible from cycle k+1.
- Timed ops: ACTIVE occupies cycles k+1..k+dur. HOLD occupies k+dur+1..k+dur+SETTLE. done and cmd_ready are high at k+dur+SETTLE+1.
- MIX: the phase-0 value 110 appears at k+1. p returns to 111 on the first HOLD cycle.
- Back-to-back: the next command may be accepted in the done cycle. Its valves open the following cycle.
- c/p never change directly from one open set to another; a closed HOLD of ≥SETTLE cycles always intervenes.

## Test plan
1. **FILL, sel=1, dur=5**, accepted at cycle 0.
   - Cycles 1–5: c=1FFF with c[1]=c[3]=0, i.e. 13'h1FF5.
   - Cycles 6–13: c=1FFF, busy=1.
   - Cycle 14: done=1, cmd_ready=1.
2. **MIX, dur=2**, accepted at 0.
   - p = 110, 100, 101, 001, 011, 010, each for 4 cycles, twice, over cycles 1–48. c=1FFF throughout.
   - p=111 over 49–56. done at 57.
3. **DISPENSE, sel=3'b101** (in7 → out2), dur=3.
   - Cycles 1–3: c[8]=c[10]=c[12]=0, others 1 (13'h0AFF).
   - done at cycle 12.
4. **Illegal and zero-length commands.**
   - FILL sel=6: err=1 at cycle 1, c unchanged, cmd_ready stays 1, no done.
   - FILL dur=0 at 0: busy 1–8, done at 9, no valve opens.
5. **Abort in ACTIVE.** FILL sel=0, dur=10; abort at cycle 3.
   - Cycle 4: c=1FFF.
   - Cycles 4–11: busy=1.
   - Cycle 12: ready=1, no done pulse.
6. **Reset mid-MIX.** rst high at cycle 20 of a MIX with dur=5.
   - Cycle 21: p=111, c=1FFF, busy=0, cmd_ready=1.
   - A new FILL accepted at cycle 21 opens its valves at cycle 22.
